alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_alu.sv | 37 +++
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - ALU operation codes (OP_*), used by the ALU datapath and by requesters
//   - FSM state encoding (ST_*) of the arbiter, also visible on its debug port
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU control codes; every code not listed yields a zero result.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    // Arbiter FSM encoding.
    localparam int         STATE_W = 2;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
// Purely combinational ALU used as the arbiter's only datapath.
// Ports:
//   op_i      [2:0]        operation code (see alu_pkg OP_*)
//   a_i, b_i  [WIDTH-1:0]  operands
//   result_o  [WIDTH-1:0]  result; add/sub wrap modulo 2^WIDTH
//   zero_o                 high when result_o is all zeros
// -----------------------------------------------------------------------------
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            // Unsigned compare, result is 1 or 0 in the LSB.
            OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters with round-robin arbitration.
// One operation is in flight at a time: IDLE (accept) -> EXEC (compute and
// register result) -> RESP (hold result until the owner consumes it).
//
// Handshake semantics (both request and response sides): a transfer happens
// on a rising clk edge where valid and ready are both high. reqN_ready is a
// combinational grant in IDLE only; rspN_valid is high in RESP for the
// owner only, and the non-owner's rsp_ready is ignored.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/reqN_ready         request handshake, N = 0,1
//   reqN_in1/reqN_in2 [WIDTH-1:0] operands, sampled only at the accept edge
//   reqN_op [2:0]                 ALU operation code
//   rspN_valid/rspN_ready         response handshake, N = 0,1
//   rsp_result [WIDTH-1:0]        shared result, qualified by rspN_valid
//   rsp_zero                      shared zero flag of rsp_result
//   busy                          high whenever the FSM is not IDLE
//   ops_done [15:0]               wrapping count of response handshakes
//   dbg_state_o [1:0]             current FSM state (alu_pkg ST_*)
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req0_in1,
    input  logic [WIDTH-1:0]   req0_in2,
    input  logic [WIDTH-1:0]   req1_in1,
    input  logic [WIDTH-1:0]   req1_in2,
    input  logic [2:0]         req0_op,
    input  logic [2:0]         req1_op,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    input  logic               rsp0_ready,
    input  logic               rsp1_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_zero,
    output logic               busy,
    output logic [15:0]        ops_done,
    output logic [STATE_W-1:0] dbg_state_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               owner_q, owner_d;   // requester id of the in-flight op
    logic               last_q, last_d;     // requester id granted most recently
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic [15:0]        ops_done_q, ops_done_d;

    logic               grant0, grant1;
    logic               owner_rsp_ready;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_zero;

    alu_arbiter_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Round-robin: a lone requester always wins; on a tie the requester that
    // was not granted last wins (last_q == 1 means requester 1 went last).
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid && (!req1_valid || last_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        zero_d     = zero_q;
        ops_done_d = ops_done_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    last_d  = grant1;
                    op_d    = grant1 ? req1_op  : req0_op;
                    a_d     = grant1 ? req1_in1 : req0_in1;
                    b_d     = grant1 ? req1_in2 : req0_in2;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (owner_rsp_ready) begin
                    ops_done_d = ops_done_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;     // requester 0 wins the first tie
            op_q       <= 3'b000;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            ops_done_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rsp0_valid  = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid  = (state_q == ST_RESP) &&  owner_q;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign busy        = (state_q != ST_IDLE);
    assign ops_done    = ops_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [2:0]   req0_op, req1_op;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         busy;
  logic [15:0]  ops_done;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // reference state, kept in terms of the rules rather than the RTL
  int           model_last = 1;   // requester granted most recently
  int           model_ops  = 0;   // completed response handshakes
  logic [W-1:0] exp_q[$];

  alu_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .req0_in1    (req0_in1),
    .req0_in2    (req0_in2),
    .req1_in1    (req1_in1),
    .req1_in2    (req1_in2),
    .req0_op     (req0_op),
    .req1_op     (req1_op),
    .rsp0_valid  (rsp0_valid),
    .rsp1_valid  (rsp1_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp1_ready  (rsp1_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .busy        (busy),
    .ops_done    (ops_done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference ALU ----------------
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua, ub, m;
    ua = longint'(a);
    ub = longint'(b);
    m  = 64'd1 << W;
    case (op)
      3'd0:    return W'((ua + ub) % m);
      3'd1:    return W'((ua + m - ub) % m);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return (ua < ub) ? W'(1) : W'(0);
      default: return W'(0);
    endcase
  endfunction

  // ---------------- driver: one complete transaction ----------------
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input int delay);
    int           w;
    logic [W-1:0] exp_r;
    @(negedge clk);
    req0_valid = v0; req0_op = op0; req0_in1 = a0; req0_in2 = b0;
    req1_valid = v1; req1_op = op1; req1_in1 = a1; req1_in2 = b1;
    if (v0 && v1) w = (model_last == 1) ? 0 : 1;
    else          w = v0 ? 0 : 1;
    #1;
    checks++;
    if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin
      errors++;
      $display("FAIL grant: ready0/1=%b%b required %b%b", req0_ready, req1_ready, w == 0, w == 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: busy=%b required 0", busy);
    end
    exp_q.push_back((w == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1));
    model_last = w;

    // accept edge; afterwards scramble inputs: they must be ignored now
    @(posedge clk); #1;
    req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
    req0_in1 = $urandom; req0_in2 = $urandom; req1_in1 = $urandom; req1_in2 = $urandom;
    req0_op = 3'($urandom_range(0, 7)); req1_op = 3'($urandom_range(0, 7));
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1 ||
        rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL exec_phase: ready=%b%b busy=%b rsp_valid=%b%b required 00 1 00",
               req0_ready, req1_ready, busy, rsp0_valid, rsp1_valid);
    end

    // second edge after accept: response visible
    @(posedge clk); #1;
    exp_r = exp_q.pop_front();
    checks++;
    if (rsp0_valid !== (w == 0) || rsp1_valid !== (w == 1)) begin
      errors++;
      $display("FAIL rsp_owner: rsp_valid0/1=%b%b required %b%b", rsp0_valid, rsp1_valid, w == 0, w == 1);
    end
    checks++;
    if (rsp_result !== exp_r || rsp_zero !== (exp_r == '0)) begin
      errors++;
      $display("FAIL rsp_data: result=%h zero=%b required %h %b", rsp_result, rsp_zero, exp_r, exp_r == '0);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL resp_ready: ready=%b%b required 00", req0_ready, req1_ready);
    end

    // backpressure; the non-owner's ready is pulsed and must be ignored
    for (int i = 0; i < delay; i++) begin
      if (w == 0) rsp1_ready = ~rsp1_ready;
      else        rsp0_ready = ~rsp0_ready;
      @(posedge clk); #1;
      checks++;
      if (rsp0_valid !== (w == 0) || rsp1_valid !== (w == 1) || rsp_result !== exp_r ||
          rsp_zero !== (exp_r == '0) || busy !== 1'b1 || ops_done !== 16'(model_ops)) begin
        errors++;
        $display("FAIL rsp_hold: cyc=%0d valid=%b%b result=%h busy=%b ops=%0d required %b%b %h 1 %0d",
                 i, rsp0_valid, rsp1_valid, rsp_result, busy, ops_done, w == 0, w == 1, exp_r, 16'(model_ops));
      end
    end

    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = (w == 0); rsp1_ready = (w == 1);
    @(posedge clk); #1;
    model_ops++;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'(model_ops)) begin
      errors++;
      $display("FAIL handshake: valid=%b%b busy=%b ops_done=%0d required 00 0 %0d",
               rsp0_valid, rsp1_valid, busy, ops_done, 16'(model_ops));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_in1 = '0; req0_in2 = '0; req1_in1 = '0; req1_in2 = '0;
    req0_op = 3'd0; req1_op = 3'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
        rsp_result !== '0 || rsp_zero !== 1'b0 || ops_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b%b result=%h zero=%b ops=%0d required all 0",
               busy, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, ops_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_single();
    run_txn(1, 0, 3'b000, 32'd7, 32'd5, 3'b000, 32'd0, 32'd0, 0);
  endtask

  task automatic test_tie();
    // fresh reset makes requester 0 the first tie winner
    run_txn(1, 1, 3'b001, 32'd9, 32'd9, 3'b011, 32'hF0, 32'h0F, 1);
    run_txn(0, 1, 3'b000, 32'd0, 32'd0, 3'b011, 32'hF0, 32'h0F, 0);
    run_txn(1, 1, 3'b010, 32'hFF00, 32'h0FF0, 3'b000, 32'd1, 32'd2, 0);
    run_txn(1, 1, 3'b000, 32'd3, 32'd4, 3'b001, 32'd1, 32'd2, 0);
  endtask

  task automatic test_slt_backpressure();
    run_txn(0, 1, 3'b000, 32'd0, 32'd0, 3'b101, 32'hFFFF_FFFF, 32'd1, 5);
    run_txn(1, 0, 3'b101, 32'd1, 32'hFFFF_FFFF, 3'b000, 32'd0, 32'd0, 2);
  endtask

  task automatic test_undefined_op();
    run_txn(1, 0, 3'b110, 32'h1234, 32'h5678, 3'b000, 32'd0, 32'd0, 4);
    run_txn(1, 0, 3'b111, 32'hFFFF, 32'h1, 3'b000, 32'd0, 32'd0, 0);
    run_txn(0, 1, 3'b000, 32'd0, 32'd0, 3'b100, 32'h8, 32'h9, 3);
  endtask

  task automatic test_wrap();
    run_txn(1, 0, 3'b000, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 32'd0, 0);
    run_txn(0, 1, 3'b000, 32'd0, 32'd0, 3'b001, 32'd0, 32'd1, 0);
  endtask

  task automatic test_reset_in_exec();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'b000; req0_in1 = 32'd1; req0_in2 = 32'd1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_last = 1;
    model_ops  = 0;
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || ops_done !== 16'd0 ||
        rsp_result !== '0 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_exec: busy=%b valid=%b%b ops=%0d result=%h zero=%b required all 0",
               busy, rsp0_valid, rsp1_valid, ops_done, rsp_result, rsp_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b valid=%b%b required 0 00", busy, rsp0_valid, rsp1_valid);
    end
    // release mid-cycle so the next rising edge is the first one after reset
    rst_n = 1'b1;
    run_txn(1, 1, 3'b011, 32'hA0, 32'h05, 3'b000, 32'd1, 32'd1, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] corner [4];
    corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000; corner[3] = 32'h1;
    for (int n = 0; n < 40; n++) begin
      bit           v0, v1;
      logic [W-1:0] a0, b0, a1, b1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      b0 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      run_txn(v0, v1, 3'($urandom_range(0, 7)), a0, b0, 3'($urandom_range(0, 7)), a1, b1,
              int'($urandom_range(0, 3)));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_single();
    // restart so the tie scenario starts from the reset grant pointer
    test_reset();
    model_last = 1;
    model_ops  = 0;
    test_tie();
    test_slt_backpressure();
    test_undefined_op();
    test_wrap();
    test_reset_in_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
